// File: rtl/cia_sp_pkg.sv
// Shared types and defaults for the CIA serial-port link partner.
package cia_sp_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOW,
        TX_HIGH,
        TX_GAP,
        TX_FLAG
    } tx_state_e;

    localparam int BIT_CNT_W           = 3;
    localparam int DEFAULT_HALF_PERIOD = 4;
    localparam int DEFAULT_RX_TIMEOUT  = 64;

endpackage

// File: rtl/cia_sp_rx.sv
// Receive side: samples SP on CIA-driven CNT rising edges, assembles bytes MSB first,
// and abandons a partial byte after RX_TIMEOUT quiet phi2 ticks.
module cia_sp_rx
    import cia_sp_pkg::*;
#(
    parameter int RX_TIMEOUT = DEFAULT_RX_TIMEOUT
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       phi2_p,
    input  logic       cnt_in,
    input  logic       sp_in,
    input  logic       tx_idle,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_active
);

    logic                 cnt_q;
    logic                 cnt_prev;
    logic                 sp_q;
    logic                 edge_seen;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           rx_shift;
    logic [15:0]          to_cnt;

    // Edges are only honoured while our own transmitter is silent (half duplex).
    assign edge_seen = cnt_q & ~cnt_prev & tx_idle;
    assign rx_active = (bit_cnt != '0);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_q    <= 1'b1;
            cnt_prev <= 1'b1;
            sp_q     <= 1'b1;
            bit_cnt  <= '0;
            rx_shift <= '0;
            to_cnt   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (phi2_p) begin
                cnt_q    <= cnt_in;
                cnt_prev <= cnt_q;
                sp_q     <= sp_in;
                if (edge_seen) begin
                    // An edge on the timeout tick still completes the byte.
                    rx_shift <= {rx_shift[6:0], sp_q};
                    bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                    to_cnt   <= '0;
                    if (&bit_cnt) begin
                        rx_data  <= {rx_shift[6:0], sp_q};
                        rx_valid <= 1'b1;
                    end
                end else if (rx_active) begin
                    if (to_cnt == 16'(RX_TIMEOUT - 1)) begin
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                        rx_err  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end else begin
                    to_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/cia_sp_peer.sv
// Link partner for the 6526 CIA serial port: clocks bytes into a CIA on CNT/SP and
// receives bytes the CIA shifts out, half duplex.
module cia_sp_peer
    import cia_sp_pkg::*;
#(
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD,
    parameter int RX_TIMEOUT  = DEFAULT_RX_TIMEOUT
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       phi2_p,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy,
    input  logic       cnt_in,
    input  logic       sp_in,
    output logic       cnt_out,
    output logic       sp_out,
    output logic       flag_n
);

    localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

    tx_state_e            state;
    logic [7:0]           tx_shift;
    logic [7:0]           hp_cnt;
    logic [BIT_CNT_W-1:0] tx_bits;
    logic                 hp_done;
    logic                 hp_first;
    logic                 rx_active;

    assign hp_done  = (hp_cnt == HP_LAST);
    assign hp_first = (hp_cnt == 8'd0);
    assign tx_ready = (state == TX_IDLE) && !rx_active;
    assign busy     = (state != TX_IDLE) || rx_active;

    cia_sp_rx #(
        .RX_TIMEOUT (RX_TIMEOUT)
    ) u_rx (
        .clk       (clk),
        .res_n     (res_n),
        .phi2_p    (phi2_p),
        .cnt_in    (cnt_in),
        .sp_in     (sp_in),
        .tx_idle   (state == TX_IDLE),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .rx_active (rx_active)
    );

    // Line levels change on the first tick of each state; hp_cnt counts ticks within it.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state    <= TX_IDLE;
            tx_shift <= '0;
            hp_cnt   <= '0;
            tx_bits  <= '0;
            cnt_out  <= 1'b1;
            sp_out   <= 1'b1;
            flag_n   <= 1'b1;
        end else begin
            unique case (state)
                TX_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_shift <= tx_data;
                        hp_cnt   <= '0;
                        tx_bits  <= '0;
                        state    <= TX_LOW;
                    end
                end
                TX_LOW: begin
                    if (phi2_p) begin
                        hp_cnt <= hp_done ? '0 : hp_cnt + 8'd1;
                        if (hp_first) begin
                            cnt_out <= 1'b0;
                            sp_out  <= tx_shift[7];
                        end
                        if (hp_done) state <= TX_HIGH;
                    end
                end
                TX_HIGH: begin
                    if (phi2_p) begin
                        hp_cnt <= hp_done ? '0 : hp_cnt + 8'd1;
                        if (hp_first) cnt_out <= 1'b1;
                        if (hp_done) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            tx_bits  <= tx_bits + BIT_CNT_W'(1);
                            state    <= (&tx_bits) ? TX_GAP : TX_LOW;
                        end
                    end
                end
                TX_GAP: begin
                    // Covers the CIA's extra cycle moving the shifter into SDR.
                    if (phi2_p) begin
                        hp_cnt <= hp_done ? '0 : hp_cnt + 8'd1;
                        if (hp_first) sp_out <= 1'b1;
                        if (hp_done) state <= TX_FLAG;
                    end
                end
                TX_FLAG: begin
                    if (phi2_p) begin
                        hp_cnt <= '0;
                        if (flag_n) begin
                            flag_n <= 1'b0;
                        end else begin
                            flag_n <= 1'b1;
                            state  <= TX_IDLE;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cia_sp_peer.sv
// Bench for cia_sp_peer: acts as the CIA on both directions and scores bytes and line timing.
module tb_cia_sp_peer;

    localparam int HP = 4;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       res_n;
    logic       phi2_p = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       busy;
    logic       cnt_in;
    logic       sp_in;
    logic       cnt_out;
    logic       sp_out;
    logic       flag_n;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] got[$];
    logic [7:0] rx_got[$];
    int         err_cnt = 0;

    bit         mon_en = 1'b0;
    int         tick_no = 0;
    int         run = 0;
    int         bits = 0;
    int         gap_run = 0;
    int         start_tick = 0;
    int         flag_tick = 0;
    logic       pc = 1'b1;
    logic       pf = 1'b1;
    logic [7:0] sh = 8'h00;

    cia_sp_peer #(
        .HALF_PERIOD (HP),
        .RX_TIMEOUT  (TO)
    ) dut (
        .clk      (clk),
        .res_n    (res_n),
        .phi2_p   (phi2_p),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .busy     (busy),
        .cnt_in   (cnt_in),
        .sp_in    (sp_in),
        .cnt_out  (cnt_out),
        .sp_out   (sp_out),
        .flag_n   (flag_n)
    );

    always #5 clk = ~clk;

    initial begin
        int ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            phi2_p = (ph == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        do @(posedge clk); while (phi2_p !== 1'b1);
        #1;
    endtask

    // Offer a byte and return just after the accepting edge; tx_valid stays high.
    task automatic tx_hs(input logic [7:0] d);
        bit ok = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("tx_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        tick();
        tick();
    endtask

    task automatic send_tx(input logic [7:0] d);
        tx_hs(d);
        tx_valid = 1'b0;
        tick();
        chk("tx_start_low", cnt_out, 0);
        tx_exp.push_back(d);
        wait_idle();
    endtask

    // CIA in output mode: SP set while CNT low, CNT held 3 ticks per level.
    task automatic send_rx(input logic [7:0] d, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            sp_in  = d[i];
            cnt_in = 1'b0;
            repeat (3) tick();
            cnt_in = 1'b1;
            if (i == 0) begin
                tick();
                tick();
                chk("rx_latency_valid", rx_valid, 1);
                chk("rx_latency_data", rx_data, d);
                tick();
            end else begin
                repeat (3) tick();
            end
        end
        sp_in = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rx_valid) rx_got.push_back(rx_data);
        if (rx_err) err_cnt++;
    end

    // CIA in input mode: shifts sp_out on cnt_out rising edges and times every line level.
    always begin
        tick();
        tick_no++;
        if (!mon_en) begin
            pc   = cnt_out;
            pf   = flag_n;
            run  = 0;
            bits = 0;
        end else begin
            run++;
            if (cnt_out !== pc) begin
                if (pc == 1'b0) chk("cnt_low_len", run, HP);
                else if (bits != 0) chk("cnt_high_len", run, HP);
                else gap_run = run;
                if (cnt_out == 1'b0 && bits == 0) start_tick = tick_no;
                if (cnt_out == 1'b1) begin
                    sh = {sh[6:0], sp_out};
                    bits++;
                    if (bits == 8) begin
                        got.push_back(sh);
                        bits = 0;
                    end
                end
                run = 0;
                pc  = cnt_out;
            end
            if (flag_n !== pf) begin
                if (flag_n == 1'b0) begin
                    flag_tick = tick_no;
                    chk("flag_lines_idle", {cnt_out, sp_out}, 2'b11);
                end else begin
                    chk("flag_len", tick_no - flag_tick, 1);
                    chk("tx_dur", tick_no - start_tick, 17 * HP + 1);
                end
                pf = flag_n;
            end
        end
    end

    initial begin
        logic [7:0] r;
        logic [7:0] t;
        int         early;
        res_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        cnt_in   = 1'b1;
        sp_in    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt_out", cnt_out, 1);
        chk("rst_sp_out", sp_out, 1);
        chk("rst_flag_n", flag_n, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_err", rx_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 1);
        res_n = 1'b1;

        // Reset mid-transmit: 10th tick of 0xA5 sits in the second LOW (bit value 0).
        tx_hs(8'hA5);
        tx_valid = 1'b0;
        repeat (10) tick();
        chk("mid_cnt_low", cnt_out, 0);
        chk("mid_sp_bit1", sp_out, 0);
        chk("mid_busy", busy, 1);
        res_n = 1'b0;
        #1;
        chk("arst_cnt_out", cnt_out, 1);
        chk("arst_sp_out", sp_out, 1);
        chk("arst_flag_n", flag_n, 1);
        chk("arst_busy", busy, 0);
        @(posedge clk);
        #1;
        res_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", tx_ready, 1);
        tick();
        mon_en = 1'b1;
        tick();

        send_tx(8'hA5);
        send_rx(8'h3C, 8);
        rx_exp.push_back(8'h3C);

        // Timeout: 3 edges then silence; the error lands exactly TO ticks after the last edge.
        send_rx(8'($urandom), 3);
        chk("to_partial_busy", busy, 1);
        repeat (62) tick();
        chk("to_not_early", err_cnt, 0);
        tick();
        chk("to_err_pulse", rx_err, 1);
        chk("to_rx_data_kept", rx_data, 8'h3C);
        tick();
        chk("to_count_cleared", busy, 0);
        send_rx(8'hFF, 8);
        rx_exp.push_back(8'hFF);

        // Back-to-back with tx_valid held throughout.
        tx_hs(8'h01);
        tx_hs(8'h80);
        tx_valid = 1'b0;
        tx_exp.push_back(8'h01);
        tx_exp.push_back(8'h80);
        wait_idle();
        chk("b2b_gap_ticks", gap_run, 2 * HP + 2);

        // Half-duplex contention: TX requested after the 4th RX edge.
        r = 8'($urandom);
        t = 8'($urandom);
        rx_exp.push_back(r);
        tx_exp.push_back(t);
        fork
            send_rx(r, 8);
            begin
                repeat (24) tick();
                tx_data  = t;
                tx_valid = 1'b1;
                early    = 0;
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (rx_valid) break;
                    if (tx_ready) early++;
                end
                chk("hd_ready_before_rx", early, 0);
                chk("hd_ready_at_rx", tx_ready, 1);
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
                tick();
                chk("hd_tx_start", cnt_out, 0);
            end
        join
        wait_idle();

        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(1) == 0) begin
                send_tx(8'($urandom));
            end else begin
                r = 8'($urandom);
                rx_exp.push_back(r);
                send_rx(r, 8);
            end
        end
        tick();

        chk("tx_byte_count", got.size(), tx_exp.size());
        for (int k = 0; k < tx_exp.size() && k < got.size(); k++)
            chk($sformatf("tx_byte_%0d", k), got[k], tx_exp[k]);
        chk("rx_byte_count", rx_got.size(), rx_exp.size());
        for (int k = 0; k < rx_exp.size() && k < rx_got.size(); k++)
            chk($sformatf("rx_byte_%0d", k), rx_got[k], rx_exp[k]);
        chk("rx_err_total", err_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
